// File: rtl/fir_seq_controller_pkg.sv
// Shared types and register-map helpers for the FIR sequencing controller.
package fir_ctrl_pkg;

  // ALU operation codes understood by the FIR datapath.
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_COPY  = 3'd1,
    OP_LOAD1 = 3'd2,
    OP_LOAD2 = 3'd3,
    OP_ADD   = 3'd4,
    OP_SUB   = 3'd5,
    OP_MUL   = 3'd6
  } op_t;

  // Controller states.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_EIDLE = 4'd1,
    ST_STORE = 4'd2,
    ST_ZERO  = 4'd3,
    ST_SHIFT = 4'd4,
    ST_MUL   = 4'd5,
    ST_ACC   = 4'd6,
    ST_LOAD  = 4'd7,
    ST_LWAIT = 4'd8
  } state_t;

  // Sample history slot k (R1 holds the oldest sample).
  function automatic logic [3:0] sample_addr(input logic [2:0] k);
    return {1'b0, k};
  endfunction

  // Coefficient ck lives just above the staging register R(N+1).
  function automatic logic [3:0] coef_addr(input logic [2:0] k, input logic [2:0] n);
    return {1'b0, n} + 4'd1 + {1'b0, k};
  endfunction

  // Product scratch register sits above the last coefficient.
  function automatic logic [3:0] temp_addr(input logic [2:0] n);
    return {n, 1'b0} + 4'd2;
  endfunction

endpackage

// File: rtl/fir_seq_controller_if.sv
// Handshake and register-file control bundle between controller and FIR datapath.
interface fir_seq_controller_if;
  import fir_ctrl_pkg::*;

  logic       dr;
  logic       lc;
  logic       overflow;
  logic       cnt_up;
  logic       clear;
  logic       modwait;
  op_t        op;
  logic [3:0] src1;
  logic [3:0] src2;
  logic [3:0] dest;
  logic       err;

  modport master (
    input  dr, lc, overflow,
    output cnt_up, clear, modwait, op, src1, src2, dest, err
  );

  modport slave (
    output dr, lc, overflow,
    input  cnt_up, clear, modwait, op, src1, src2, dest, err
  );
endinterface

// File: rtl/fir_seq_controller_chk.sv
// Elaboration-time guard on the tap count (register map must fit in 4-bit addresses).
module fir_seq_controller_chk #(
  parameter int NUM_TAPS = 4
);
  if ((NUM_TAPS < 2) || (NUM_TAPS > 6)) begin : g_bad_taps
    $fatal(1, "fir_seq_controller: NUM_TAPS=%0d outside 2..6", NUM_TAPS);
  end
endmodule

// File: rtl/fir_seq_controller.sv
// Counter-driven sequencer for an N-tap FIR: coefficient load, sample shift and MAC loop.
module fir_seq_controller
  import fir_ctrl_pkg::*;
#(
  parameter int          NUM_TAPS  = 4,
  parameter logic [5:0]  SIGN_MASK = 6'b010101
) (
  input logic                  clk,
  input logic                  n_reset,
  fir_seq_controller_if.master bus
);

  localparam logic [2:0] N_K = 3'(NUM_TAPS);

  state_t     state_r;
  state_t     state_s;
  logic [2:0] k_r;
  logic [2:0] k_s;
  logic       modwait_r;

  op_t        op_s;
  logic [3:0] src1_s;
  logic [3:0] src2_s;
  logic [3:0] dest_s;
  logic       cnt_up_s;
  logic       clear_s;
  logic       err_s;
  logic [2:0] tap_idx_s;

  fir_seq_controller_chk #(.NUM_TAPS(NUM_TAPS)) u_chk ();

  // State and tap counter registers; reset aborts any sequence straight to IDLE.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_r <= ST_IDLE;
      k_r     <= 3'd0;
    end else begin
      state_r <= state_s;
      k_r     <= k_s;
    end
  end

  // Busy flag: high the cycle after any working state.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      modwait_r <= 1'b0;
    end else begin
      modwait_r <= !((state_r == ST_IDLE) || (state_r == ST_EIDLE) || (state_r == ST_LWAIT));
    end
  end

  // Next-state and tap counter update.
  always_comb begin
    state_s = state_r;
    k_s     = k_r;
    case (state_r)
      ST_IDLE, ST_EIDLE: begin
        if (bus.lc) begin
          state_s = ST_LOAD;
          k_s     = 3'd1;
        end else if (bus.dr) begin
          state_s = ST_STORE;
        end else begin
          state_s = state_r;
        end
      end
      ST_STORE: begin
        if (bus.dr) begin
          state_s = ST_ZERO;
        end else begin
          state_s = ST_EIDLE;
        end
      end
      ST_ZERO: begin
        state_s = ST_SHIFT;
        k_s     = 3'd1;
      end
      ST_SHIFT: begin
        if (k_r < N_K) begin
          k_s = k_r + 3'd1;
        end else begin
          state_s = ST_MUL;
        end
      end
      ST_MUL: begin
        state_s = ST_ACC;
      end
      ST_ACC: begin
        if (bus.overflow) begin
          state_s = ST_EIDLE;
        end else if (k_r > 3'd1) begin
          state_s = ST_MUL;
          k_s     = k_r - 3'd1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (k_r < N_K) begin
          state_s = ST_LWAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LWAIT: begin
        if (bus.lc) begin
          state_s = ST_LOAD;
          k_s     = k_r + 3'd1;
        end else begin
          state_s = ST_LWAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        k_s     = 3'd0;
      end
    endcase
  end

  // Datapath control decoded from state and tap counter.
  always_comb begin
    op_s      = OP_NOP;
    src1_s    = 4'd0;
    src2_s    = 4'd0;
    dest_s    = 4'd0;
    cnt_up_s  = 1'b0;
    clear_s   = 1'b0;
    err_s     = 1'b0;
    tap_idx_s = k_r - 3'd1;
    case (state_r)
      ST_EIDLE: begin
        err_s = 1'b1;
      end
      ST_STORE: begin
        op_s   = OP_LOAD1;
        dest_s = coef_addr(3'd0, N_K);
      end
      ST_ZERO: begin
        op_s     = OP_SUB;
        cnt_up_s = 1'b1;
      end
      ST_SHIFT: begin
        op_s   = OP_COPY;
        src1_s = sample_addr(k_r + 3'd1);
        dest_s = sample_addr(k_r);
      end
      ST_MUL: begin
        op_s   = OP_MUL;
        src1_s = sample_addr(k_r);
        src2_s = coef_addr(k_r, N_K);
        dest_s = temp_addr(N_K);
      end
      ST_ACC: begin
        if (SIGN_MASK[tap_idx_s]) begin
          op_s = OP_SUB;
        end else begin
          op_s = OP_ADD;
        end
        src2_s = temp_addr(N_K);
      end
      ST_LOAD: begin
        op_s    = OP_LOAD2;
        dest_s  = coef_addr(k_r, N_K);
        clear_s = 1'b1;
      end
      default: begin
        op_s = OP_NOP;
      end
    endcase
  end

  assign bus.op      = op_s;
  assign bus.src1    = src1_s;
  assign bus.src2    = src2_s;
  assign bus.dest    = dest_s;
  assign bus.cnt_up  = cnt_up_s;
  assign bus.clear   = clear_s;
  assign bus.err     = err_s;
  assign bus.modwait = modwait_r;

endmodule

// File: doc/fir_seq_controller.md
Name: fir_seq_controller

Overview:
- Parametrised sequencing controller for the N-tap FIR datapath (register file, ALU, sample counter).
- Loads NUM_TAPS coefficients on successive lc strobes.
- On each dr, stores the new sample, clears the accumulator, shifts the sample history, then runs NUM_TAPS multiply/accumulate pairs with a per-tap add/subtract selected by SIGN_MASK.
- Replaces a fixed 4-tap unrolled FSM with a counter-driven FSM.

Parameters:
- NUM_TAPS, 4, number of taps; legal range 2..6 (bounded by the 4-bit register address space).
- SIGN_MASK, 6'b010101, bit k-1 = 1 makes tap k subtract, 0 makes it add; bits at NUM_TAPS and above are ignored.

Ports:
- clk  in  1  clock, rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- dr  in  1  data ready; new sample present on datapath input.
- lc  in  1  load coefficient strobe.
- overflow  in  1  ALU overflow flag for the current op.
- cnt_up  out  1  one-cycle pulse to the sample counter.
- clear  out  1  clears the sample counter during coefficient load.
- modwait  out  1  registered busy flag.
- op  out  3  ALU op (encoding below).
- src1  out  4  register file read address 1.
- src2  out  4  register file read address 2.
- dest  out  4  register file write address.
- err  out  1  error flag.

Behaviour:
- Register map (N = NUM_TAPS):
  - R0 = accumulator.
  - R1..RN = sample history, R1 oldest.
  - R(N+1) = new-sample staging.
  - R(N+2)..R(2N+1) = coefficients c1..cN.
  - R(2N+2) = product temp.
  - For N=4: samples 1..5, coefficients 6..9, temp 10.
- op encoding: NOP=0, COPY=1, LOAD1=2, LOAD2=3, ADD=4, SUB=5, MUL=6.
- Outputs are combinational from state and counter. Defaults: all zero, op=NOP.
- Reset: state=IDLE, tap counter k=0, modwait=0. All outputs read 0 while in reset. Reset mid-sequence aborts immediately to IDLE; no partial result is flagged.
- States: IDLE, EIDLE, STORE, ZERO, SHIFT, MUL, ACC, LOAD, LWAIT.
- IDLE / EIDLE:
  - lc=1 → LOAD with k=1. lc has priority when lc and dr are high together.
  - else dr=1 → STORE.
  - else hold.
  - err=1 only in EIDLE. EIDLE is sticky until lc or dr.
- STORE: op=LOAD1, dest=N+1.
  - dr still 1 → ZERO.
  - dr dropped → EIDLE (sample glitch error).
- ZERO: op=SUB, src1=src2=dest=0, cnt_up=1. Next: SHIFT with k=1.
- SHIFT: op=COPY, src1=k+1, dest=k.
  - k<N → k+1, stay in SHIFT.
  - k=N → MUL with k=N.
- MUL: op=MUL, src1=k, src2=N+1+k, dest=2N+2. Next: ACC.
- ACC: op = SIGN_MASK[k-1] ? SUB : ADD, src1=0, src2=2N+2, dest=0.
  - overflow=1 → EIDLE (checked every ACC, including the last).
  - else k>1 → k-1, go to MUL.
  - else (k=1) → IDLE.
- LOAD: op=LOAD2, dest=N+1+k, clear=1.
  - k<N → LWAIT.
  - k=N → IDLE.
- LWAIT: outputs default; hold until lc=1, then k+1 → LOAD.
  - dr in LWAIT is ignored; coefficient load is not interruptible except by reset.
- modwait timing: modwait(t+1) = 1 iff state(t) is not IDLE, EIDLE or LWAIT. It therefore rises the cycle after STORE/LOAD is entered and falls one cycle after returning to IDLE/EIDLE/LWAIT.
- Latency: a sample sequence occupies 3N+2 cycles from STORE to IDLE (14 for N=4).
- Tap counter: 3 bits, never wraps outside 1..N within a sequence.
- Elaboration check: fatal assertion if NUM_TAPS<2 or NUM_TAPS>6.

Decomposition:
- Package fir_ctrl_pkg holds:
  - op_t enum (the 7 op codes).
  - state_t enum.
  - Address helper functions sample_addr(k), coef_addr(k,N), temp_addr(N).
- Sub-module: none required. The tap counter stays inline, since its load/increment/decrement depends directly on state.

Test Plan:
- Reset check: assert n_reset=0 mid-MUL → state IDLE; modwait, err, cnt_up, clear all 0; op=NOP.
- Coefficient load, N=4: lc pulsed 4 times with 3-cycle gaps → LOAD2 writes to dest 6, 7, 8, 9; clear=1 on each; modwait high only on the cycle after each LOAD; returns to IDLE.
- Sample sequence, N=4, SIGN_MASK=6'b010101: dr held 2 cycles → dest sequence 5, 0, 1, 2, 3, 4, then MUL(4,9), ADD, MUL(3,8), SUB, MUL(2,7), ADD, MUL(1,6), SUB; cnt_up exactly once; 14 busy cycles; no err.
- Glitch error: dr high 1 cycle only → STORE then EIDLE, err=1. A following dr → STORE with err back to 0.
- Overflow error: overflow=1 during the second ACC → EIDLE, err=1, no further MUL issued; modwait falls the next cycle.
- Parameter sweep, N=2 and N=6, SIGN_MASK=0: temp address 6 and 14 respectively; every ACC is ADD; latency 8 and 20 cycles.
